i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter at the output end of the channel strip. It accepts one signed 16-bit stereo sample pair per frame from the filter chain through a valid/ready handshake and double-buffers it. It serializes each pair MSB-first onto a standard I2S link (BCLK, LRCLK, SDATA) toward the codec DAC. BCLK and LRCLK are derived internally from the single system clock.

## Interface
- WIDTH, 16: sample width in bits; also the number of data bits sent per slot.
- SLOT, 32: BCLK periods per channel slot; must be ≥ WIDTH+1.
- BCLK_DIV, 2: clk_48 cycles per BCLK half-period; must be ≥ 1.
- clk_48  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  left_in/right_in hold a valid pair.
- left_in  input  WIDTH  signed left sample.
- right_in  input  WIDTH  signed right sample.
- sample_ready  output  1  the holding register is empty.
- bclk  output  1  bit clock.
- lrclk  output  1  word select; 0 = left slot, 1 = right slot.
- sdata  output  1  serial data.
- underrun  output  1  one-cycle pulse when a frame starts with no sample available.

## Operation
- Divider counter div counts 0..BCLK_DIV-1. On each terminal count, bclk toggles.
- A toggle from 1 to 0 is a fall event. bitcnt (0..2·SLOT-1) advances by one on each fall event and wraps at 2·SLOT-1 back to 0.
- All of lrclk, sdata, bitcnt and the load logic are registered and update only on the clk_48 cycle of a fall event. Data therefore changes on falling BCLK and is stable at rising BCLK.
- lrclk = 0 for bitcnt 0..SLOT-1 and 1 for SLOT..2·SLOT-1.
- sdata at bitcnt k = 1..WIDTH carries active left bit [WIDTH-k]. This gives the I2S one-BCLK delay, MSB first.
- sdata at bitcnt k = SLOT+1..SLOT+WIDTH carries active right bit [WIDTH-(k-SLOT)].
- sdata is 0 at all other bitcnt values.
- Holding register: the pair is loaded when sample_valid && sample_ready, and sample_ready then drops on the next cycle. sample_ready = ~holding_full.
- Frame start is the fall event where bitcnt wraps to 0. On that cycle:
  - If holding is full, the holding pair moves into the active registers and holding is cleared, so sample_ready rises next cycle.
  - Bypass: if holding is empty and a handshake occurs in the same cycle, the incoming pair goes directly into the active registers and holding stays empty. No underrun.
  - Otherwise the active registers are loaded with 0, underrun pulses high for exactly this cycle, and silence is sent.
- A handshake on any non-frame-start cycle fills holding only. Data offered while sample_ready = 0 is not accepted, and the upstream block must hold it.
- Samples are transmitted bit-exact with no saturation or rounding.

## Timing
- Reset values:
  - Outputs: bclk=0, lrclk=1, sdata=0, sample_ready=1, underrun=0.
  - Internal: div=0, bitcnt=2·SLOT-1, holding and active registers = 0.
- Reset asserted mid-frame takes effect immediately and asynchronously. The link restarts from reset values, and the pending holding pair is discarded.
- After reset deasserts, the first bclk rise is at cycle BCLK_DIV. The first fall event is at cycle 2·BCLK_DIV, and it is a frame start.
- Frame period is 2·SLOT·2·BCLK_DIV clk_48 cycles, which is 256 at the defaults.
- Latency: a pair accepted before frame start F has its left MSB on sdata one BCLK period (2·BCLK_DIV cycles) after F.
- Throughput: one pair per frame. sample_ready returns the cycle after each frame start.

## Test plan
- Basic serialization: reset, then present left=16'h8001 and right=16'h7FFE before the first frame start.
  - Expect the left slot sdata as BCLK periods 1..16 = 1,0×14,1, with padding 0 in periods 17..31.
  - Expect the right slot sdata = 0,1×14,0 in periods 33..48.
  - Expect lrclk low for 32 BCLK periods and high for 32.
- Underrun: no sample_valid after reset. Expect underrun high for exactly 1 cycle at cycle 4 and every 256 cycles, with sdata constantly 0.
- Backpressure: present pair A, then pair B continuously.
  - Expect sample_ready low from A's acceptance until the cycle after the next frame start.
  - Expect B to be accepted then, and A and B to be sent in consecutive frames with no underrun.
- Bypass: raise sample_valid only on the exact frame-start cycle while holding is empty.
  - Expect no underrun pulse and the pair transmitted in that same frame.
  - Expect sample_ready to remain 1.
- Reset mid-frame: assert reset at bitcnt 20 while holding is full.
  - Expect all outputs at reset values immediately.
  - After release, expect a frame start at cycle 4 with an underrun pulse, since the held pair was discarded.
- Parameter check with BCLK_DIV=1: expect a bclk period of 2 cycles, a frame period of 128 cycles, and the same bit ordering as the first scenario.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Sample handshake bundle between the filter chain and i2s_tx.
// master = upstream producer, slave = i2s_tx.
interface i2s_tx_if #(
  parameter int WIDTH = 16
);
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;

  modport master (
    output sample_valid,
    output left_in,
    output right_in,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  left_in,
    input  right_in,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: double-buffered stereo pair in, BCLK/LRCLK/SDATA out.
// Ports: clk_48, reset (async high), bus (sample handshake), bclk, lrclk, sdata, underrun.
module i2s_tx #(
  parameter int WIDTH    = 16,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 2
) (
  input  logic clk_48,
  input  logic reset,
  i2s_tx_if.slave bus,
  output logic bclk,
  output logic lrclk,
  output logic sdata,
  output logic underrun
);

  localparam int CW = $clog2(2 * SLOT);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT - 1);

  logic [DW-1:0]    r_div;
  logic             r_bclk;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_underrun;
  logic [CW-1:0]    r_bitcnt;
  logic             r_full;
  logic [WIDTH-1:0] r_hold_l;
  logic [WIDTH-1:0] r_hold_r;
  logic [WIDTH-1:0] r_act_l;
  logic [WIDTH-1:0] r_act_r;
  logic [WIDTH-1:0] r_sh;

  logic          w_tc;
  logic          w_fall;
  logic          w_fs;
  logic          w_hs;
  logic [CW-1:0] w_nb;
  logic          w_ld_l;
  logic          w_ld_r;
  logic          w_shift;

  assign w_tc   = (r_div == DW'(BCLK_DIV - 1));
  assign w_fall = w_tc & r_bclk;
  assign w_fs   = w_fall & (r_bitcnt == LAST);
  assign w_hs   = bus.sample_valid & ~r_full;
  assign w_nb   = (r_bitcnt == LAST) ? '0 : r_bitcnt + 1'b1;

  // Slot MSB is loaded one BCLK after the slot edge (I2S delay),
  // the remaining WIDTH-1 bits come out of the shifter.
  assign w_ld_l  = (w_nb == CW'(1));
  assign w_ld_r  = (w_nb == CW'(SLOT + 1));
  assign w_shift =
    ((w_nb >= CW'(2)) && (w_nb <= CW'(WIDTH))) ||
    ((w_nb >= CW'(SLOT + 2)) &&
     (w_nb <= CW'(SLOT + WIDTH)));

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  // Holding/active double buffer. At frame start an empty holding
  // register lets a same-cycle handshake bypass straight to active.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_act_l    <= '0;
      r_act_r    <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_fs) begin
        if (r_full) begin
          r_act_l <= r_hold_l;
          r_act_r <= r_hold_r;
          r_full  <= 1'b0;
        end else if (w_hs) begin
          r_act_l <= bus.left_in;
          r_act_r <= bus.right_in;
        end else begin
          r_act_l    <= '0;
          r_act_r    <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_hold_l <= bus.left_in;
        r_hold_r <= bus.right_in;
        r_full   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_bitcnt <= LAST;
      r_lrclk  <= 1'b1;
      r_sdata  <= 1'b0;
      r_sh     <= '0;
    end else if (w_fall) begin
      r_bitcnt <= w_nb;
      r_lrclk  <= (w_nb >= CW'(SLOT));
      unique case (1'b1)
        w_ld_l: begin
          r_sdata <= r_act_l[WIDTH-1];
          r_sh    <= r_act_l << 1;
        end
        w_ld_r: begin
          r_sdata <= r_act_r[WIDTH-1];
          r_sh    <= r_act_r << 1;
        end
        w_shift: begin
          r_sdata <= r_sh[WIDTH-1];
          r_sh    <= r_sh << 1;
        end
        default: r_sdata <= 1'b0;
      endcase
    end
  end

  assign bclk             = r_bclk;
  assign lrclk            = r_lrclk;
  assign sdata            = r_sdata;
  assign underrun         = r_underrun;
  assign bus.sample_ready = ~r_full;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default instance plus a BCLK_DIV=1 instance.
// Frames are captured one BCLK sample per period into 64-bit words.
module tb_i2s_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if #(.WIDTH(16)) if1 ();
  i2s_tx_if #(.WIDTH(16)) if2 ();

  logic bclk1, lrclk1, sdata1, ur1;
  logic bclk2, lrclk2, sdata2, ur2;

  i2s_tx #(.WIDTH(16), .SLOT(32), .BCLK_DIV(2)) u_dut1 (
    .clk_48   (clk),
    .reset    (reset),
    .bus      (if1),
    .bclk     (bclk1),
    .lrclk    (lrclk1),
    .sdata    (sdata1),
    .underrun (ur1)
  );

  i2s_tx #(.WIDTH(16), .SLOT(32), .BCLK_DIV(1)) u_dut2 (
    .clk_48   (clk),
    .reset    (reset),
    .bus      (if2),
    .bclk     (bclk2),
    .lrclk    (lrclk2),
    .sdata    (sdata2),
    .underrun (ur2)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic sel = 1'b0;

  logic m_bclk, m_lr, m_sd, m_ur, m_rdy;
  assign m_bclk = sel ? bclk2 : bclk1;
  assign m_lr   = sel ? lrclk2 : lrclk1;
  assign m_sd   = sel ? sdata2 : sdata1;
  assign m_ur   = sel ? ur2 : ur1;
  assign m_rdy  = sel ? if2.sample_ready : if1.sample_ready;

  localparam logic [63:0] LR_EXP = 64'hFFFFFFFF_00000000;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic steps_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if1.sample_valid = 1'b0;
    if2.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic drive1(input logic v,
                        input logic [15:0] l,
                        input logic [15:0] r);
    if1.sample_valid = v;
    if1.left_in = l;
    if1.right_in = r;
  endtask

  // Call on the frame-start cycle; returns on the next one.
  task automatic cap(input int div,
                     output logic [63:0] sd,
                     output logic [63:0] lr,
                     output logic [3:0] bc,
                     output int ur,
                     output int rdy);
    sd = '0; lr = '0; bc = '0; ur = 0; rdy = 0;
    for (int p = 0; p < 64; p++) begin
      for (int s = 0; s < 2 * div; s++) begin
        if (p == 0 && s < 4) bc[s] = m_bclk;
        if (s == div) begin
          sd[p] = m_sd;
          lr[p] = m_lr;
        end
        ur += int'(m_ur);
        rdy += int'(m_rdy);
        step();
      end
    end
  endtask

  logic [63:0] sd, lr;
  logic [3:0] bc;
  int ur, rdy;

  initial begin
    drive1(1'b0, '0, '0);
    if2.sample_valid = 1'b0;
    if2.left_in = '0;
    if2.right_in = '0;

    // basic serialization
    do_reset();
    chk("rst_bclk", 64'(bclk1), 64'd0);
    chk("rst_lrclk", 64'(lrclk1), 64'd1);
    chk("rst_sdata", 64'(sdata1), 64'd0);
    chk("rst_ready", 64'(if1.sample_ready), 64'd1);
    chk("rst_under", 64'(ur1), 64'd0);
    drive1(1'b1, 16'h8001, 16'h7FFE);
    step();
    chk("acc_ready", 64'(if1.sample_ready), 64'd0);
    drive1(1'b0, 16'h0, 16'h0);
    steps_to(4);
    chk("fs_ready", 64'(if1.sample_ready), 64'd1);
    chk("fs_under", 64'(ur1), 64'd0);
    cap(2, sd, lr, bc, ur, rdy);
    chk("b_sdata", sd, 64'h0000FFFC_00010002);
    chk("b_lrclk", lr, LR_EXP);
    chk("b_bclk", 64'(bc), 64'(4'b1100));
    chk("b_ur", 64'(ur), 64'd0);

    // underrun
    do_reset();
    steps_to(3);
    chk("u_c3", 64'(ur1), 64'd0);
    step();
    chk("u_c4", 64'(ur1), 64'd1);
    cap(2, sd, lr, bc, ur, rdy);
    chk("u_cnt", 64'(ur), 64'd1);
    chk("u_sdata", sd, 64'd0);
    chk("u_c260", 64'(ur1), 64'd1);
    step();
    chk("u_c261", 64'(ur1), 64'd0);

    // backpressure
    do_reset();
    drive1(1'b1, 16'hF00F, 16'h8000);
    step();
    drive1(1'b1, 16'h0001, 16'hFFFF);
    chk("bp_c1", 64'(if1.sample_ready), 64'd0);
    steps_to(3);
    chk("bp_c3", 64'(if1.sample_ready), 64'd0);
    step();
    chk("bp_c4", 64'(if1.sample_ready), 64'd1);
    cap(2, sd, lr, bc, ur, rdy);
    chk("bp_a_sd", sd, 64'h00000002_0001E01E);
    chk("bp_a_ur", 64'(ur), 64'd0);
    chk("bp_a_rdy", 64'(rdy), 64'd1);
    chk("bp_c260", 64'(if1.sample_ready), 64'd1);
    cap(2, sd, lr, bc, ur, rdy);
    chk("bp_b_sd", sd, 64'h0001FFFE_00010000);
    chk("bp_b_ur", 64'(ur), 64'd0);
    drive1(1'b0, 16'h0, 16'h0);

    // bypass on the frame-start cycle
    do_reset();
    steps_to(3);
    drive1(1'b1, 16'h5555, 16'h0003);
    step();
    drive1(1'b0, 16'h0, 16'h0);
    chk("by_ur", 64'(ur1), 64'd0);
    cap(2, sd, lr, bc, ur, rdy);
    chk("by_sd", sd, 64'h00018000_00015554);
    chk("by_urcnt", 64'(ur), 64'd0);
    chk("by_rdy", 64'(rdy), 64'd256);

    // reset mid-frame with holding full
    do_reset();
    drive1(1'b1, 16'h1111, 16'h2222);
    step();
    drive1(1'b0, 16'h0, 16'h0);
    steps_to(4);
    drive1(1'b1, 16'hBEEF, 16'hCAFE);
    step();
    drive1(1'b0, 16'h0, 16'h0);
    steps_to(85);
    chk("mr_pre_rdy", 64'(if1.sample_ready), 64'd0);
    chk("mr_pre_lr", 64'(lrclk1), 64'd0);
    reset = 1'b1;
    #1;
    chk("mr_bclk", 64'(bclk1), 64'd0);
    chk("mr_lrclk", 64'(lrclk1), 64'd1);
    chk("mr_sdata", 64'(sdata1), 64'd0);
    chk("mr_ready", 64'(if1.sample_ready), 64'd1);
    chk("mr_under", 64'(ur1), 64'd0);
    do_reset();
    steps_to(3);
    chk("mr_c3", 64'(ur1), 64'd0);
    step();
    chk("mr_c4", 64'(ur1), 64'd1);

    // BCLK_DIV = 1 instance
    do_reset();
    sel = 1'b1;
    if2.sample_valid = 1'b1;
    if2.left_in = 16'h8001;
    if2.right_in = 16'h7FFE;
    step();
    if2.sample_valid = 1'b0;
    chk("d1_acc", 64'(if2.sample_ready), 64'd0);
    steps_to(2);
    chk("d1_fs_rdy", 64'(if2.sample_ready), 64'd1);
    cap(1, sd, lr, bc, ur, rdy);
    chk("d1_sd", sd, 64'h0000FFFC_00010002);
    chk("d1_lr", lr, LR_EXP);
    chk("d1_bclk", 64'(bc), 64'(4'b0010));
    chk("d1_ur", 64'(ur), 64'd0);
    chk("d1_c130", 64'(ur2), 64'd1);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
